// File: rtl/clock_alarm_datapath_if.sv
// Controller-side bundle for the alarm clock datapath.
// The controller (master) drives tick, mode, field enables and the
// up/down pulses. The datapath (slave) returns the registered time,
// alarm and match flag.
interface clock_alarm_datapath_if;
    logic       tick_1hz;
    logic       adjust;
    logic [4:0] en;
    logic       up;
    logic       down;
    logic [4:0] t_hour;
    logic [5:0] t_min;
    logic [5:0] t_sec;
    logic [4:0] a_hour;
    logic [5:0] a_min;
    logic       z;

    modport master (
        output tick_1hz, adjust, en, up, down,
        input  t_hour, t_min, t_sec, a_hour, a_min, z
    );

    modport slave (
        input  tick_1hz, adjust, en, up, down,
        output t_hour, t_min, t_sec, a_hour, a_min, z
    );
endinterface

// File: rtl/clock_alarm_datapath.sv
// Timekeeping and alarm-storage datapath for the digital alarm clock.
// Keeps a 24-hour time of day (hh:mm:ss) and an alarm setting (hh:mm).
// Run mode advances time on tick_1hz. Adjust mode freezes time and
// steps the field picked by the one-hot enable vector. z is the
// registered match of time hh:mm against the alarm in run mode.
//
// Optional build macro: SEC_CLEAR_ON_ADJ_EN
//   defined   - an effective step of time hours or minutes also zeroes
//               the seconds counter on the same edge.
//   undefined - seconds only ever change through tick_1hz.
module clock_alarm_datapath (
    input  logic                   clk,
    input  logic                   rst,
    clock_alarm_datapath_if.slave  bus
);

    localparam logic [4:0] HOUR_MAX = 5'd23;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [5:0] SEC_MAX  = 6'd59;

    // Field that an up/down pulse acts on after priority resolution.
    typedef enum logic [2:0] {
        FLD_NONE,
        FLD_T_HOUR,
        FLD_T_MIN,
        FLD_A_HOUR,
        FLD_A_MIN
    } field_e;

    // Hours step with wrap 23 <-> 0.
    function automatic logic [4:0] step_hour(input logic [4:0] v, input logic inc);
        logic [4:0] r;
        if (inc) r = (v == HOUR_MAX) ? 5'd0 : v + 5'd1;
        else     r = (v == 5'd0) ? HOUR_MAX : v - 5'd1;
        return r;
    endfunction

    // Minutes step with wrap 59 <-> 0.
    function automatic logic [5:0] step_min(input logic [5:0] v, input logic inc);
        logic [5:0] r;
        if (inc) r = (v == MIN_MAX) ? 6'd0 : v + 6'd1;
        else     r = (v == 6'd0) ? MIN_MAX : v - 6'd1;
        return r;
    endfunction

    logic [4:0] t_hour_q, t_hour_d;
    logic [5:0] t_min_q,  t_min_d;
    logic [5:0] t_sec_q,  t_sec_d;
    logic [4:0] a_hour_q, a_hour_d;
    logic [5:0] a_min_q,  a_min_d;
    logic       z_q,      z_d;

    field_e     field_sel;
    logic       step_valid;
    logic       step_inc;
    logic       sec_clear;

    // en[0] has no field behind it; it is kept on the bus for the controller.
    logic       en_unused;
    assign en_unused = bus.en[0];

    // Opposing pulses in the same cycle cancel; otherwise up wins the direction.
    assign step_valid = bus.up ^ bus.down;
    assign step_inc   = bus.up;

    // Resolve the enable vector to a single field, time hours highest.
    // NOTE: every variable written in always_comb gets a default first, so
    // no path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        field_sel = FLD_NONE;
        if      (bus.en[4]) field_sel = FLD_T_HOUR;
        else if (bus.en[3]) field_sel = FLD_T_MIN;
        else if (bus.en[2]) field_sel = FLD_A_HOUR;
        else if (bus.en[1]) field_sel = FLD_A_MIN;
    end

`ifdef SEC_CLEAR_ON_ADJ_EN
    // A real time-field step restarts the minute from :00.
    logic time_field;
    assign time_field = (field_sel == FLD_T_HOUR) || (field_sel == FLD_T_MIN);
    assign sec_clear  = bus.adjust && step_valid && time_field;
`else
    // Seconds are untouched by adjustment; they only freeze.
    assign sec_clear  = 1'b0;
`endif

    // Next-state: adjust steps one field, run mode ripples the tick through
    // seconds, minutes and hours; alarm fields move only by adjustment.
    always_comb begin
        t_hour_d = t_hour_q;
        t_min_d  = t_min_q;
        t_sec_d  = t_sec_q;
        a_hour_d = a_hour_q;
        a_min_d  = a_min_q;

        if (bus.adjust) begin
            // Ticks arriving while adjusting are dropped, not queued.
            if (step_valid) begin
                unique case (field_sel)
                    FLD_T_HOUR: t_hour_d = step_hour(t_hour_q, step_inc);
                    FLD_T_MIN:  t_min_d  = step_min(t_min_q, step_inc);
                    FLD_A_HOUR: a_hour_d = step_hour(a_hour_q, step_inc);
                    FLD_A_MIN:  a_min_d  = step_min(a_min_q, step_inc);
                    default:    ;
                endcase
            end
            if (sec_clear) begin
                t_sec_d = '0;
            end
        end else if (bus.tick_1hz) begin
            if (t_sec_q == SEC_MAX) begin
                t_sec_d = '0;
                if (t_min_q == MIN_MAX) begin
                    t_min_d  = '0;
                    t_hour_d = step_hour(t_hour_q, 1'b1);
                end else begin
                    t_min_d = t_min_q + 6'd1;
                end
            end else begin
                t_sec_d = t_sec_q + 6'd1;
            end
        end
    end

    // Match on the current registered hh:mm; seconds are deliberately ignored
    // so z stays up for the whole matching minute.
    assign z_d = !bus.adjust && (t_hour_q == a_hour_q) && (t_min_q == a_min_q);

    // State registers with asynchronous active-high clear.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and the update order inside the block is irrelevant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_hour_q <= '0;
            t_min_q  <= '0;
            t_sec_q  <= '0;
            a_hour_q <= '0;
            a_min_q  <= '0;
            z_q      <= 1'b0;
        end else begin
            t_hour_q <= t_hour_d;
            t_min_q  <= t_min_d;
            t_sec_q  <= t_sec_d;
            a_hour_q <= a_hour_d;
            a_min_q  <= a_min_d;
            z_q      <= z_d;
        end
    end

    assign bus.t_hour = t_hour_q;
    assign bus.t_min  = t_min_q;
    assign bus.t_sec  = t_sec_q;
    assign bus.a_hour = a_hour_q;
    assign bus.a_min  = a_min_q;
    assign bus.z      = z_q;

endmodule

// File: tb/tb_clock_alarm_datapath.sv
// Self-checking bench for clock_alarm_datapath. A reference model keeps
// time as seconds-of-day; each driven cycle pushes the model's expected
// outputs to a queue that is popped and compared after the clock edge.
module tb_clock_alarm_datapath;

    logic clk;
    logic rst;

    clock_alarm_datapath_if bus ();

    clock_alarm_datapath dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic [4:0] ah;
        logic [5:0] am;
        logic       z;
    } exp_t;

    exp_t exp_q[$];

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state.
    int m_h, m_m, m_s, m_ah, m_am;

    task automatic model_clear();
        m_h = 0; m_m = 0; m_s = 0; m_ah = 0; m_am = 0;
        exp_q.delete();
    endtask

    // Drive one clock cycle of stimulus, predict, then compare after the edge.
    task automatic cycle(input bit tick, input bit adj, input logic [4:0] en_v,
                         input bit up_v, input bit down_v);
        exp_t e;
        int   tot;
        bus.tick_1hz = tick;
        bus.adjust   = adj;
        bus.en       = en_v;
        bus.up       = up_v;
        bus.down     = down_v;

        e.z = !adj && (m_h == m_ah) && (m_m == m_am);
        if (adj) begin
            if (up_v != down_v) begin
                if (en_v[4]) begin
                    m_h = (m_h + (up_v ? 1 : 23)) % 24;
`ifdef SEC_CLEAR_ON_ADJ_EN
                    m_s = 0;
`endif
                end else if (en_v[3]) begin
                    m_m = (m_m + (up_v ? 1 : 59)) % 60;
`ifdef SEC_CLEAR_ON_ADJ_EN
                    m_s = 0;
`endif
                end else if (en_v[2]) begin
                    m_ah = (m_ah + (up_v ? 1 : 23)) % 24;
                end else if (en_v[1]) begin
                    m_am = (m_am + (up_v ? 1 : 59)) % 60;
                end
            end
        end else if (tick) begin
            tot = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
            m_h = tot / 3600;
            m_m = (tot / 60) % 60;
            m_s = tot % 60;
        end
        e.h  = 5'(m_h);
        e.m  = 6'(m_m);
        e.s  = 6'(m_s);
        e.ah = 5'(m_ah);
        e.am = 6'(m_am);
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        bus.tick_1hz = 1'b0;
        bus.up       = 1'b0;
        bus.down     = 1'b0;

        e = exp_q.pop_front();
        tests_run++;
        if ({bus.t_hour, bus.t_min, bus.t_sec, bus.a_hour, bus.a_min, bus.z} !==
            {e.h, e.m, e.s, e.ah, e.am, e.z}) begin
            tests_failed++;
            $display("FAIL scoreboard @%0t: got %0d:%0d:%0d alarm %0d:%0d z=%b, expected %0d:%0d:%0d alarm %0d:%0d z=%b",
                     $time, bus.t_hour, bus.t_min, bus.t_sec, bus.a_hour, bus.a_min, bus.z,
                     e.h, e.m, e.s, e.ah, e.am, e.z);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.tick_1hz = 1'b0; bus.adjust = 1'b0; bus.en = '0; bus.up = 1'b0; bus.down = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({bus.t_hour, bus.t_min, bus.t_sec, bus.a_hour, bus.a_min, bus.z} !== 29'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d:%0d:%0d alarm %0d:%0d z=%b, expected all zero",
                     bus.t_hour, bus.t_min, bus.t_sec, bus.a_hour, bus.a_min, bus.z);
        end
        #2 rst = 1'b0;
    endtask

    task automatic test_run_day();
        for (int i = 1; i <= 3600; i++) begin
            cycle(1'b1, 1'b0, 5'b00000, 1'b0, 1'b0);
            if (i == 60) begin
                tests_run++;
                if ({bus.t_hour, bus.t_min, bus.t_sec} !== {5'd0, 6'd1, 6'd0}) begin
                    tests_failed++;
                    $display("FAIL tick_60: got %0d:%0d:%0d, expected 0:1:0",
                             bus.t_hour, bus.t_min, bus.t_sec);
                end
            end
        end
        tests_run++;
        if ({bus.t_hour, bus.t_min, bus.t_sec} !== {5'd1, 6'd0, 6'd0}) begin
            tests_failed++;
            $display("FAIL tick_3600: got %0d:%0d:%0d, expected 1:0:0",
                     bus.t_hour, bus.t_min, bus.t_sec);
        end
        // Jump to 23:00:00 and let the last hour of the day run out.
        cycle(1'b0, 1'b1, 5'b10000, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 5'b10000, 1'b0, 1'b1);
        for (int i = 0; i < 3600; i++) cycle(1'b1, 1'b0, 5'b00000, 1'b0, 1'b0);
        tests_run++;
        if ({bus.t_hour, bus.t_min, bus.t_sec} !== 17'd0) begin
            tests_failed++;
            $display("FAIL day_rollover: got %0d:%0d:%0d, expected 0:0:0",
                     bus.t_hour, bus.t_min, bus.t_sec);
        end
    endtask

    task automatic test_alarm_adjust();
        repeat (3) cycle(1'b0, 1'b1, 5'b00101, 1'b0, 1'b1);
        tests_run++;
        if (bus.a_hour !== 5'd21) begin
            tests_failed++;
            $display("FAIL alarm_hour_down: got %0d, expected 21", bus.a_hour);
        end
        cycle(1'b0, 1'b1, 5'b00011, 1'b0, 1'b1);
        tests_run++;
        if ({bus.a_hour, bus.a_min} !== {5'd21, 6'd59}) begin
            tests_failed++;
            $display("FAIL alarm_min_down: got %0d:%0d, expected 21:59", bus.a_hour, bus.a_min);
        end
    endtask

    task automatic test_wrap();
        cycle(1'b0, 1'b1, 5'b10000, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 5'b01000, 1'b0, 1'b1);
        repeat (59) cycle(1'b1, 1'b0, 5'b00000, 1'b0, 1'b0);
        tests_run++;
        if ({bus.t_hour, bus.t_min, bus.t_sec} !== {5'd23, 6'd59, 6'd59}) begin
            tests_failed++;
            $display("FAIL set_235959: got %0d:%0d:%0d, expected 23:59:59",
                     bus.t_hour, bus.t_min, bus.t_sec);
        end
        cycle(1'b1, 1'b0, 5'b00000, 1'b0, 1'b0);
        tests_run++;
        if ({bus.t_hour, bus.t_min, bus.t_sec, bus.a_hour, bus.a_min} !==
            {5'd0, 6'd0, 6'd0, 5'd21, 6'd59}) begin
            tests_failed++;
            $display("FAIL wrap_tick: got %0d:%0d:%0d alarm %0d:%0d, expected 0:0:0 alarm 21:59",
                     bus.t_hour, bus.t_min, bus.t_sec, bus.a_hour, bus.a_min);
        end
    endtask

    task automatic test_match();
        repeat (3) cycle(1'b0, 1'b1, 5'b00100, 1'b1, 1'b0);   // alarm hour 21 -> 0
        repeat (3) cycle(1'b0, 1'b1, 5'b00010, 1'b1, 1'b0);   // alarm min 59 -> 2
        cycle(1'b0, 1'b1, 5'b01000, 1'b1, 1'b0);              // time 00:01:00
        repeat (59) cycle(1'b1, 1'b0, 5'b00000, 1'b0, 1'b0);  // 00:01:59
        cycle(1'b1, 1'b0, 5'b00000, 1'b0, 1'b0);              // tick 1 -> 00:02:00
        tests_run++;
        if (bus.z !== 1'b0) begin
            tests_failed++;
            $display("FAIL z_lag: got z=%b, expected 0", bus.z);
        end
        cycle(1'b0, 1'b0, 5'b00000, 1'b0, 1'b0);
        tests_run++;
        if (bus.z !== 1'b1) begin
            tests_failed++;
            $display("FAIL z_rise: got z=%b, expected 1", bus.z);
        end
        for (int k = 2; k <= 60; k++) begin
            cycle(1'b1, 1'b0, 5'b00000, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, 5'b00000, 1'b0, 1'b0);
            tests_run++;
            if (bus.z !== 1'b1) begin
                tests_failed++;
                $display("FAIL z_hold tick %0d: got z=%b, expected 1", k, bus.z);
            end
        end
        cycle(1'b1, 1'b0, 5'b00000, 1'b0, 1'b0);              // tick 61 -> 00:03:00
        cycle(1'b0, 1'b0, 5'b00000, 1'b0, 1'b0);
        tests_run++;
        if (bus.z !== 1'b0) begin
            tests_failed++;
            $display("FAIL z_fall_minute: got z=%b, expected 0", bus.z);
        end
        cycle(1'b0, 1'b1, 5'b00010, 1'b1, 1'b0);              // alarm 00:03 while adjusting
        tests_run++;
        if (bus.z !== 1'b0) begin
            tests_failed++;
            $display("FAIL z_adjust_block: got z=%b, expected 0", bus.z);
        end
        cycle(1'b0, 1'b0, 5'b00000, 1'b0, 1'b0);
        tests_run++;
        if (bus.z !== 1'b1) begin
            tests_failed++;
            $display("FAIL z_leave_adjust: got z=%b, expected 1", bus.z);
        end
        repeat (3) cycle(1'b1, 1'b0, 5'b00000, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 5'b00000, 1'b0, 1'b0);
        tests_run++;
        if (bus.z !== 1'b0) begin
            tests_failed++;
            $display("FAIL z_adjust_rise: got z=%b, expected 0", bus.z);
        end
    endtask

    task automatic test_simultaneous();
        int h0, m0, s0, ah0, am0;
        h0 = m_h; m0 = m_m; s0 = m_s; ah0 = m_ah; am0 = m_am;
        cycle(1'b1, 1'b1, 5'b01000, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 5'b00000, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 5'b00001, 1'b1, 1'b0);
        tests_run++;
        if ({bus.t_hour, bus.t_min, bus.t_sec, bus.a_hour, bus.a_min} !==
            {5'(h0), 6'(m0), 6'(s0), 5'(ah0), 6'(am0)}) begin
            tests_failed++;
            $display("FAIL no_change: got %0d:%0d:%0d alarm %0d:%0d, expected %0d:%0d:%0d alarm %0d:%0d",
                     bus.t_hour, bus.t_min, bus.t_sec, bus.a_hour, bus.a_min, h0, m0, s0, ah0, am0);
        end
        cycle(1'b1, 1'b1, 5'b11110, 1'b1, 1'b0);
        tests_run++;
        if ({bus.t_hour, bus.t_min, bus.a_hour, bus.a_min} !==
            {5'((h0 + 1) % 24), 6'(m0), 5'(ah0), 6'(am0)}) begin
            tests_failed++;
            $display("FAIL priority: got %0d:%0d alarm %0d:%0d, expected %0d:%0d alarm %0d:%0d",
                     bus.t_hour, bus.t_min, bus.a_hour, bus.a_min, (h0 + 1) % 24, m0, ah0, am0);
        end
        cycle(1'b0, 1'b1, 5'b10000, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset();
        repeat (5) cycle(1'b1, 1'b0, 5'b00000, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({bus.t_hour, bus.t_min, bus.t_sec, bus.a_hour, bus.a_min, bus.z} !== 29'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got %0d:%0d:%0d alarm %0d:%0d z=%b, expected all zero",
                     bus.t_hour, bus.t_min, bus.t_sec, bus.a_hour, bus.a_min, bus.z);
        end
        model_clear();
        @(posedge clk);
        #3 rst = 1'b0;
        repeat (2) cycle(1'b1, 1'b0, 5'b00000, 1'b0, 1'b0);
    endtask

    task automatic test_sec_clear();
        // Resume from whatever the previous test left; bring time to 10:20:37.
        while (m_h != 10) cycle(1'b0, 1'b1, 5'b10000, 1'b1, 1'b0);
        while (m_m != 20) cycle(1'b0, 1'b1, 5'b01000, 1'b1, 1'b0);
        while (m_s != 37) cycle(1'b1, 1'b0, 5'b00000, 1'b0, 1'b0);
        tests_run++;
        if ({bus.t_hour, bus.t_min, bus.t_sec} !== {5'd10, 6'd20, 6'd37}) begin
            tests_failed++;
            $display("FAIL set_102037: got %0d:%0d:%0d, expected 10:20:37",
                     bus.t_hour, bus.t_min, bus.t_sec);
        end
        cycle(1'b0, 1'b1, 5'b00100, 1'b1, 1'b0);
        tests_run++;
        if (bus.t_sec !== 6'd37) begin
            tests_failed++;
            $display("FAIL alarm_keeps_sec: got %0d, expected 37", bus.t_sec);
        end
        cycle(1'b0, 1'b1, 5'b01000, 1'b1, 1'b0);
        tests_run++;
`ifdef SEC_CLEAR_ON_ADJ_EN
        if ({bus.t_hour, bus.t_min, bus.t_sec} !== {5'd10, 6'd21, 6'd0}) begin
            tests_failed++;
            $display("FAIL sec_clear: got %0d:%0d:%0d, expected 10:21:0",
                     bus.t_hour, bus.t_min, bus.t_sec);
        end
`else
        if ({bus.t_hour, bus.t_min, bus.t_sec} !== {5'd10, 6'd21, 6'd37}) begin
            tests_failed++;
            $display("FAIL sec_keep: got %0d:%0d:%0d, expected 10:21:37",
                     bus.t_hour, bus.t_min, bus.t_sec);
        end
`endif
        cycle(1'b0, 1'b0, 5'b00000, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_run_day();
        test_alarm_adjust();
        test_wrap();
        test_match();
        test_simultaneous();
        test_async_reset();
        test_sec_clear();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
